// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel operand loader for the 8-leaf adder tree: packs a valid/ready
// operand stream into eight registered leaf lanes with a sequential golden sum.
module adder_tree_operand_loader #(
   parameter int ADDER_WIDTH = 7
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [ADDER_WIDTH-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [ADDER_WIDTH-1:0] isum0_0_0_0,
   output logic [ADDER_WIDTH-1:0] isum0_0_0_1,
   output logic [ADDER_WIDTH-1:0] isum0_0_1_0,
   output logic [ADDER_WIDTH-1:0] isum0_0_1_1,
   output logic [ADDER_WIDTH-1:0] isum0_1_0_0,
   output logic [ADDER_WIDTH-1:0] isum0_1_0_1,
   output logic [ADDER_WIDTH-1:0] isum0_1_1_0,
   output logic [ADDER_WIDTH-1:0] isum0_1_1_1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             out_count,
   output logic [ADDER_WIDTH+2:0] ref_sum
);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                 r_state;
   logic [2:0]             r_idx;
   logic [ADDER_WIDTH-1:0] r_lane [8];
   logic [ADDER_WIDTH+2:0] r_sum;
   logic [3:0]             r_count;
   logic                   r_outValid;

   logic w_accept;
   logic w_close;
   logic w_release;

   assign in_ready  = (r_state == FILL);
   assign w_accept  = in_valid & in_ready;
   assign w_close   = (r_idx == 3'd7) | in_last;
   assign w_release = r_outValid & out_ready;

   // Lanes are cleared on release so an early-closed group leaves zeros in unused leaves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= FILL;
         r_idx      <= 3'd0;
         r_sum      <= '0;
         r_count    <= 4'd0;
         r_outValid <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_lane[i] <= '0;
         end
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  r_lane[r_idx] <= in_data;
                  r_sum         <= r_sum + {3'b000, in_data};
                  r_count       <= {1'b0, r_idx} + 4'd1;
                  if (w_close) begin
                     r_state    <= FULL;
                     r_outValid <= 1'b1;
                     r_idx      <= 3'd0;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            FULL: begin
               if (w_release) begin
                  r_state    <= FILL;
                  r_outValid <= 1'b0;
                  r_sum      <= '0;
                  r_count    <= 4'd0;
                  for (int i = 0; i < 8; i++) begin
                     r_lane[i] <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign isum0_0_0_0 = r_lane[0];
   assign isum0_0_0_1 = r_lane[1];
   assign isum0_0_1_0 = r_lane[2];
   assign isum0_0_1_1 = r_lane[3];
   assign isum0_1_0_0 = r_lane[4];
   assign isum0_1_0_1 = r_lane[5];
   assign isum0_1_1_0 = r_lane[6];
   assign isum0_1_1_1 = r_lane[7];
   assign out_valid   = r_outValid;
   assign out_count   = r_count;
   assign ref_sum     = r_sum;

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Self-checking bench for adder_tree_operand_loader: directed table, hand-written
// corner sequences and random traffic against a queue-based group model.
module tb_adder_tree_operand_loader;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_count;
   logic [W+2:0] ref_sum;
   logic [W-1:0] l0, l1, l2, l3, l4, l5, l6, l7;
   logic [7:0][W-1:0] dutLanes;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [W-1:0] mGroup [$];
   bit           mPresent;

   typedef struct {
      bit                v;
      bit                last;
      bit                ordy;
      logic [W-1:0]      d;
      bit                expInReady;
      bit                expOutValid;
      logic [3:0]        expCount;
      logic [W+2:0]      expSum;
      logic [7:0][W-1:0] expLanes;
   } vec_t;

   vec_t vecs [10];

   always #5 clk = ~clk;

   assign dutLanes = {l7, l6, l5, l4, l3, l2, l1, l0};

   adder_tree_operand_loader #(.ADDER_WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready),
      .isum0_0_0_0(l0), .isum0_0_0_1(l1), .isum0_0_1_0(l2), .isum0_0_1_1(l3),
      .isum0_1_0_0(l4), .isum0_1_0_1(l5), .isum0_1_1_0(l6), .isum0_1_1_1(l7),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .ref_sum(ref_sum)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0][W-1:0] modelLanes();
      logic [7:0][W-1:0] l = '0;
      for (int i = 0; i < mGroup.size(); i++) l[i] = mGroup[i];
      return l;
   endfunction

   function automatic int modelSum();
      int s = 0;
      foreach (mGroup[i]) s += int'(mGroup[i]);
      return s;
   endfunction

   task automatic checkOutput(input string tag);
      check({tag, " in_ready"},  in_ready,  64'(!mPresent));
      check({tag, " out_valid"}, out_valid, 64'(mPresent));
      check({tag, " out_count"}, out_count, 64'(mGroup.size()));
      check({tag, " ref_sum"},   ref_sum,   64'(modelSum()));
      check({tag, " lanes"},     dutLanes,  64'(modelLanes()));
   endtask

   // One clock: drive inputs, advance the group model at the edge, then compare.
   task automatic applyStimulus(input bit v, input bit last, input logic [W-1:0] d,
                                input bit ordy, input string tag, output bit acc);
      in_valid  = v;
      in_last   = last;
      in_data   = d;
      out_ready = ordy;
      acc = v && !mPresent;
      @(posedge clk);
      if (!mPresent) begin
         if (v) begin
            mGroup.push_back(d);
            if (mGroup.size() == 8 || last) mPresent = 1'b1;
         end
      end else if (ordy) begin
         mPresent = 1'b0;
         mGroup.delete();
      end
      #1;
      checkOutput(tag);
   endtask

   task automatic resetModel();
      mPresent = 1'b0;
      mGroup.delete();
   endtask

   initial begin
      bit           acc;
      int           next;
      int           edges;
      logic [W+2:0] sums [$];

      reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      resetModel();
      #12;
      check("reset in_ready", in_ready, 64'd1);
      check("reset out_valid", out_valid, 64'd0);
      check("reset out_count", out_count, 64'd0);
      check("reset ref_sum", ref_sum, 64'd0);
      check("reset lanes", dutLanes, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int k = 0; k < 8; k++) begin
         vecs[k].v = 1'b1; vecs[k].last = 1'b0; vecs[k].ordy = 1'b1;
         vecs[k].d = W'(k + 1);
         vecs[k].expInReady  = (k != 7);
         vecs[k].expOutValid = (k == 7);
         vecs[k].expCount    = 4'(k + 1);
         vecs[k].expSum      = (W + 3)'((k + 1) * (k + 2) / 2);
         vecs[k].expLanes    = '0;
         for (int j = 0; j <= k; j++) vecs[k].expLanes[j] = W'(j + 1);
      end
      vecs[8] = '{v: 1'b1, last: 1'b0, ordy: 1'b1, d: W'(100), expInReady: 1'b1,
                  expOutValid: 1'b0, expCount: 4'd0, expSum: '0, expLanes: '0};
      vecs[9] = '{v: 1'b0, last: 1'b0, ordy: 1'b0, d: W'(0), expInReady: 1'b1,
                  expOutValid: 1'b0, expCount: 4'd0, expSum: '0, expLanes: '0};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].v, vecs[i].last, vecs[i].d, vecs[i].ordy, $sformatf("vec%0d", i), acc);
         check($sformatf("vec%0d in_ready", i), in_ready, 64'(vecs[i].expInReady));
         check($sformatf("vec%0d out_valid", i), out_valid, 64'(vecs[i].expOutValid));
         check($sformatf("vec%0d out_count", i), out_count, 64'(vecs[i].expCount));
         check($sformatf("vec%0d ref_sum", i), ref_sum, 64'(vecs[i].expSum));
         check($sformatf("vec%0d lanes", i), dutLanes, 64'(vecs[i].expLanes));
      end

      applyStimulus(1, 0, 127, 0, "early", acc);
      applyStimulus(1, 0, 127, 0, "early", acc);
      applyStimulus(1, 1, 127, 0, "early", acc);
      check("early ref_sum", ref_sum, 64'd381);
      check("early out_count", out_count, 64'd3);
      check("early lanes", dutLanes, {8'd0, 35'd0, 7'd127, 7'd127, 7'd127});

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 5, 0, "bp", acc);
         check("bp in_ready", in_ready, 64'd0);
         check("bp ref_sum held", ref_sum, 64'd381);
      end
      applyStimulus(1, 0, 5, 1, "bp release", acc);
      applyStimulus(1, 0, 5, 0, "bp next", acc);
      check("bp next lane0", l0, 64'd5);
      applyStimulus(1, 1, 6, 0, "bp close", acc);
      applyStimulus(0, 0, 0, 1, "bp drain", acc);

      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 127, 0, "max", acc);
      check("max ref_sum", ref_sum, 64'd1016);
      check("max out_count", out_count, 64'd8);
      applyStimulus(0, 0, 0, 1, "max release", acc);

      for (int i = 1; i <= 4; i++) applyStimulus(1, 0, W'(i), 0, "rstfill", acc);
      reset_n = 1'b0;
      resetModel();
      #2;
      check("rstfill lanes", dutLanes, 64'd0);
      check("rstfill out_valid", out_valid, 64'd0);
      check("rstfill ref_sum", ref_sum, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      applyStimulus(1, 0, 9, 0, "rstfill next", acc);
      check("rstfill lane0", l0, 64'd9);
      applyStimulus(1, 1, 3, 0, "rstpres", acc);
      check("rstpres out_valid before", out_valid, 64'd1);
      reset_n = 1'b0;
      resetModel();
      #2;
      check("rstpres out_valid async", out_valid, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      next = 0;
      edges = 0;
      while ((next < 16 || mPresent) && edges < 40) begin
         applyStimulus(next < 16, 0, W'(next), 1, "b2b", acc);
         edges++;
         if (acc) next++;
         if (out_valid) sums.push_back(ref_sum);
      end
      check("b2b edges", edges, 64'd18);
      check("b2b groups", sums.size(), 64'd2);
      if (sums.size() == 2) begin
         check("b2b sum0", sums[0], 64'd28);
         check("b2b sum1", sums[1], 64'd92);
      end

      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                       W'($urandom), ($urandom_range(0, 1) == 1), "rand", acc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
